// File: rtl/two_to_one_multiplexer_pkg.sv
// ---------------------------------------------------------------------------
// two_to_one_multiplexer_pkg
//   Shared constants and helpers for the byte selector.
//   - SEL_HI / SEL_LO : select encodings (0 = high byte, 1 = low byte)
//   - DATA_W_DEF      : default word width
//   - MAX_W           : widest word the helper functions accept
//   - byte_sel()      : picks one half of a word
//   - parity_of()     : even parity (XOR reduction) of a selected half
// ---------------------------------------------------------------------------
package two_to_one_multiplexer_pkg;

  localparam logic SEL_HI     = 1'b0;
  localparam logic SEL_LO     = 1'b1;
  localparam int   DATA_W_DEF = 16;
  localparam int   MAX_W      = 64;

  // The helper works on a zero-extended MAX_W word so that any even DATA_W
  // up to MAX_W can share it. half_w is the width of one output half.
  function automatic logic [MAX_W/2-1:0] byte_sel(
    input logic [MAX_W-1:0] word,
    input logic             sel,
    input int               half_w = DATA_W_DEF / 2
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] hi;
    logic [MAX_W-1:0] lo;
    logic [MAX_W-1:0] res;
    mask = {MAX_W{1'b1}} >> (MAX_W - half_w);
    hi   = (word >> half_w) & mask;
    lo   = word & mask;
    // Plain ternary so an unknown select resolves with normal ?: semantics.
    res  = (sel == SEL_LO) ? lo : hi;
    return res[MAX_W/2-1:0];
  endfunction

  // XOR reduction; upper bits beyond the real half are zero and do not
  // disturb the result.
  function automatic logic parity_of(input logic [MAX_W/2-1:0] half);
    return ^half;
  endfunction

endpackage : two_to_one_multiplexer_pkg

// File: rtl/two_to_one_multiplexer_byte_select_reg.sv
// ---------------------------------------------------------------------------
// byte_select_reg
//   Asynchronous-reset register bank for the byte selector.
//   Configuration macro: TWO_TO_ONE_MUX_PARITY_EN adds the parity register.
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous, active-high reset
//     data_d     in   HALF_W  selected byte to capture
//     sel_d      in   1       select value to capture
//     par_d      in   1       parity to capture        (parity build only)
//     data_q     out  HALF_W  registered byte, resets to 0
//     sel_q      out  1       registered select, resets to high byte
//     par_q      out  1       registered parity, resets to 0 (parity build only)
// ---------------------------------------------------------------------------
module byte_select_reg
  import two_to_one_multiplexer_pkg::*;
#(
  parameter int HALF_W = DATA_W_DEF / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HALF_W-1:0] data_d,
  input  logic              sel_d,
`ifdef TWO_TO_ONE_MUX_PARITY_EN
  input  logic              par_d,
  output logic              par_q,
`endif
  output logic [HALF_W-1:0] data_q,
  output logic              sel_q
);

  logic [HALF_W-1:0] data_r;
  logic              sel_r;

  // Capture the selected byte and its select on every edge; no enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= {HALF_W{1'b0}};
      sel_r  <= SEL_HI;
    end else begin
      data_r <= data_d;
      sel_r  <= sel_d;
    end
  end

  assign data_q = data_r;
  assign sel_q  = sel_r;

`ifdef TWO_TO_ONE_MUX_PARITY_EN
  logic par_r;

  // Parity travels in lock-step with the registered byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_r <= 1'b0;
    end else begin
      par_r <= par_d;
    end
  end

  assign par_q = par_r;
`endif

endmodule : byte_select_reg

// File: rtl/two_to_one_multiplexer.sv
// ---------------------------------------------------------------------------
// two_to_one_multiplexer
//   Byte selector for the 8-bit datapath: forwards the high or low half of
//   a DATA_W word, combinationally and as a one-cycle registered copy.
//   Configuration macro: TWO_TO_ONE_MUX_PARITY_EN adds data_par/data_par_q.
//   Ports:
//     clk         in   rising-edge clock
//     rst         in   asynchronous, active-high reset (registers only)
//     data_in     in   DATA_W    word to split
//     flip_flop   in   1         0 = high byte, 1 = low byte
//     data_out    out  DATA_W/2  selected byte, combinational
//     data_out_q  out  DATA_W/2  data_out registered on clk
//     sel_q       out  1         flip_flop registered on clk
//     data_par    out  1         ^data_out            (parity build only)
//     data_par_q  out  1         data_par registered  (parity build only)
// ---------------------------------------------------------------------------
module two_to_one_multiplexer
  import two_to_one_multiplexer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                flip_flop,
  output logic [DATA_W/2-1:0] data_out,
  output logic [DATA_W/2-1:0] data_out_q,
  output logic                sel_q
`ifdef TWO_TO_ONE_MUX_PARITY_EN
  ,
  output logic                data_par,
  output logic                data_par_q
`endif
);

  localparam int HALF_W = DATA_W / 2;

  // Zero-latency byte select; independent of clk and rst.
  always_comb begin
    data_out = HALF_W'(byte_sel(MAX_W'(data_in), flip_flop, HALF_W));
  end

`ifdef TWO_TO_ONE_MUX_PARITY_EN
  // Parity of whatever byte is currently being forwarded.
  always_comb begin
    data_par = parity_of((MAX_W/2)'(data_out));
  end
`endif

  byte_select_reg #(
    .HALF_W (HALF_W)
  ) u_regs (
    .clk    (clk),
    .rst    (rst),
    .data_d (data_out),
    .sel_d  (flip_flop),
`ifdef TWO_TO_ONE_MUX_PARITY_EN
    .par_d  (data_par),
    .par_q  (data_par_q),
`endif
    .data_q (data_out_q),
    .sel_q  (sel_q)
  );

endmodule : two_to_one_multiplexer

// File: tb/tb_two_to_one_multiplexer.sv
module tb_two_to_one_multiplexer;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic        flip_flop;
  logic [7:0]  data_out;
  logic [7:0]  data_out_q;
  logic        sel_q;
`ifdef TWO_TO_ONE_MUX_PARITY_EN
  logic        data_par;
  logic        data_par_q;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  two_to_one_multiplexer dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .flip_flop  (flip_flop),
    .data_out   (data_out),
    .data_out_q (data_out_q),
    .sel_q      (sel_q)
`ifdef TWO_TO_ONE_MUX_PARITY_EN
    ,
    .data_par   (data_par),
    .data_par_q (data_par_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: which byte a word/select pair yields, by plain arithmetic.
  function automatic logic [7:0] model_byte(input logic [15:0] w, input logic s);
    int v;
    v = int'(w);
    if (s) return 8'(v % 256);
    return 8'(v / 256);
  endfunction

  function automatic logic model_par(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return logic'(ones % 2);
  endfunction

  // Reference for the registered outputs: value captured at the last edge,
  // or zero while/after reset.
  logic [7:0] m_q;
  logic       m_sel;
  logic       m_par;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q   = 8'h00;
      m_sel = 1'b0;
      m_par = 1'b0;
    end else begin
      m_q   = model_byte(data_in, flip_flop);
      m_sel = flip_flop;
      m_par = model_par(model_byte(data_in, flip_flop));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the reference during the random phase.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rand_data_out", 32'(data_out), 32'(model_byte(data_in, flip_flop)));
      chk("rand_data_out_q", 32'(data_out_q), 32'(m_q));
      chk("rand_sel_q", 32'(sel_q), 32'(m_sel));
`ifdef TWO_TO_ONE_MUX_PARITY_EN
      chk("rand_data_par", 32'(data_par), 32'(model_par(model_byte(data_in, flip_flop))));
      chk("rand_data_par_q", 32'(data_par_q), 32'(m_par));
`endif
    end
  end

  initial begin
    rst       = 1'b1;
    data_in   = 16'h0000;
    flip_flop = 1'b0;
    #3;
    chk("reset_data_out_q", 32'(data_out_q), 32'h00);
    chk("reset_sel_q", 32'(sel_q), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Combinational selection, literal expectations.
    @(negedge clk);
    data_in = 16'hABCD; flip_flop = 1'b0; #1;
    chk("comb_abcd_hi", 32'(data_out), 32'hAB);
    flip_flop = 1'b1; #1;
    chk("comb_abcd_lo", 32'(data_out), 32'hCD);
    @(negedge clk);
    data_in = 16'h1234; flip_flop = 1'b0; #1;
    chk("comb_1234_hi", 32'(data_out), 32'h12);
    flip_flop = 1'b1; #1;
    chk("comb_1234_lo", 32'(data_out), 32'h34);

    // Registered path.
    @(negedge clk);
    data_in = 16'hBEEF; flip_flop = 1'b1;
    @(posedge clk); #1;
    chk("reg_beef_lo", 32'(data_out_q), 32'hEF);
    chk("reg_sel_lo", 32'(sel_q), 32'h1);
    flip_flop = 1'b0;
    #1;
    chk("reg_hold_between_edges", 32'(data_out_q), 32'hEF);
    @(posedge clk); #1;
    chk("reg_beef_hi", 32'(data_out_q), 32'hBE);
    chk("reg_sel_hi", 32'(sel_q), 32'h0);

    // Reset between edges clears registers only.
    flip_flop = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_q", 32'(data_out_q), 32'hEF);
    #2; rst = 1'b1; #1;
    chk("mid_rst_q", 32'(data_out_q), 32'h00);
    chk("mid_rst_sel", 32'(sel_q), 32'h0);
    chk("mid_rst_data_out", 32'(data_out), 32'hEF);
    @(posedge clk); #1;
    chk("held_rst_q", 32'(data_out_q), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_before_edge", 32'(data_out_q), 32'h00);
    @(posedge clk); #1;
    chk("post_rst_reload_q", 32'(data_out_q), 32'hEF);
    chk("post_rst_reload_sel", 32'(sel_q), 32'h1);

`ifdef TWO_TO_ONE_MUX_PARITY_EN
    @(negedge clk);
    data_in = 16'h0007; flip_flop = 1'b1; #1;
    chk("par_data_out", 32'(data_out), 32'h07);
    chk("par_comb", 32'(data_par), 32'h1);
    @(posedge clk); #1;
    chk("par_reg", 32'(data_par_q), 32'h1);
`endif

    // Random phase with occasional resets, checked every cycle.
    @(posedge clk); #2;
    chk_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      data_in   = 16'($urandom);
      flip_flop = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
      @(posedge clk); #2;
    end
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_two_to_one_multiplexer
